// File: rtl/count_multi_gate.sv
// Multi-channel start/stop/photon counter in the clk500 domain: synchronised inputs,
// stop/start/sequence timers, gated saturating photon counters and per-sequence snapshots.
module count_multi_gate #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 24,
    parameter int STOP_W      = 32,
    parameter int START_W     = 24,
    parameter int SEQ_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk500,
    input  logic                   count_rst_n,
    input  logic                   start,
    input  logic                   start_rst,
    input  logic                   photo_rst,
    input  logic [NCH-1:0]         photo,
    input  logic [START_W-1:0]     cntstart,
    input  logic [STOP_W-1:0]      cntstop,
    input  logic                   gate_en,
    input  logic [STOP_W-1:0]      win_lo,
    input  logic [STOP_W-1:0]      win_hi,
    output logic [STOP_W-1:0]      cnt_stop,
    output logic [START_W-1:0]     cnt_start,
    output logic [SEQ_W-1:0]       sequence_count,
    output logic [NCH*CNT_W-1:0]   cnt_photo,
    output logic [NCH*CNT_W-1:0]   snap_photo,
    output logic                   snap_valid,
    output logic [NCH-1:0]         ovf,
    output logic                   ready
);
    localparam int NIN  = NCH + 3;
    localparam int LAST = SYNC_STAGES - 1;

    logic [NIN-1:0]       async_in;
    logic [NIN-1:0]       det;
    logic [NIN-1:0]       pos_reg;
    logic                 start_pos;
    logic                 start_rst_pos;
    logic                 photo_rst_pos;
    logic [NCH-1:0]       photo_pos;
    logic                 in_win;

    assign async_in = {photo, photo_rst, start_rst, start};

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   hist_reg;

            always_ff @(posedge clk500) begin
                if (!count_rst_n) begin
                    sync_reg <= '0;
                    hist_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in[gi]};
                    hist_reg <= sync_reg[LAST];
                end
            end

            if (gi < 3) begin : g_ctrl
                // Control inputs need two consecutive high samples, rejecting single-sample glitches
                assign det[gi] = sync_reg[LAST] & sync_reg[LAST-1] & ~hist_reg;
            end else begin : g_photo
                assign det[gi] = sync_reg[LAST] & ~hist_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk500) begin
        if (!count_rst_n) pos_reg <= '0;
        else              pos_reg <= det;
    end

    assign start_pos     = pos_reg[0];
    assign start_rst_pos = pos_reg[1];
    assign photo_rst_pos = pos_reg[2];
    assign photo_pos     = pos_reg[NIN-1:3];

    logic [STOP_W-1:0] cnt_stop_reg;
    logic              ready_reg;

    always_ff @(posedge clk500) begin
        if (!count_rst_n) begin
            cnt_stop_reg <= '0;
            ready_reg    <= 1'b1;
        end else begin
            if (start_pos)
                cnt_stop_reg <= '0;
            else if (cnt_stop_reg != '1)
                cnt_stop_reg <= cnt_stop_reg + STOP_W'(1);
            ready_reg <= (cnt_stop_reg < cntstop);
        end
    end

    // An inverted window (win_lo > win_hi) can never satisfy both bounds, so it is empty
    assign in_win = !gate_en || ((cnt_stop_reg >= win_lo) && (cnt_stop_reg <= win_hi));

    logic [START_W-1:0] cnt_start_reg, cnt_start_next;
    logic [SEQ_W-1:0]   seq_reg, seq_next;

    always_comb begin
        cnt_start_next = cnt_start_reg;
        seq_next       = seq_reg;
        if (start_rst_pos) begin
            cnt_start_next = '0;
            seq_next       = seq_reg + SEQ_W'(1);
        end else if (start_pos) begin
            cnt_start_next = (cnt_start_reg >= cntstart) ? START_W'(1)
                                                         : cnt_start_reg + START_W'(1);
        end
    end

    always_ff @(posedge clk500) begin
        if (!count_rst_n) begin
            cnt_start_reg <= '0;
            seq_reg       <= '0;
        end else begin
            cnt_start_reg <= cnt_start_next;
            seq_reg       <= seq_next;
        end
    end

    logic [NCH*CNT_W-1:0] cnt_photo_vec;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic             ovf_reg;

            always_ff @(posedge clk500) begin
                if (!count_rst_n || photo_rst_pos) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (photo_pos[gi] && in_win) begin
                    if (cnt_reg == '1) ovf_reg <= 1'b1;
                    else               cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_photo_vec[gi*CNT_W +: CNT_W] = cnt_reg;
            assign ovf[gi]                          = ovf_reg;
        end
    endgenerate

    logic [NCH*CNT_W-1:0] snap_reg;
    logic                 snap_valid_reg;

    // Snapshot samples the counters before any same-cycle clear takes effect
    always_ff @(posedge clk500) begin
        if (!count_rst_n) begin
            snap_reg       <= '0;
            snap_valid_reg <= 1'b0;
        end else begin
            snap_valid_reg <= start_rst_pos;
            if (start_rst_pos) snap_reg <= cnt_photo_vec;
        end
    end

    assign cnt_stop       = cnt_stop_reg;
    assign cnt_start      = cnt_start_reg;
    assign sequence_count = seq_reg;
    assign cnt_photo      = cnt_photo_vec;
    assign snap_photo     = snap_reg;
    assign snap_valid     = snap_valid_reg;
    assign ready          = ready_reg;

endmodule

// File: tb/tb_count_multi_gate.sv
// Self-checking bench for count_multi_gate: timed scoreboard plus table-driven start and window vectors.
`timescale 1ns/1ps
module tb_count_multi_gate;
    localparam int NCH = 4, CNT_W = 4, STOP_W = 32, START_W = 24, SEQ_W = 32, SYNC_STAGES = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic                 clk500 = 1'b0;
    logic                 count_rst_n;
    logic                 start, start_rst, photo_rst;
    logic [NCH-1:0]       photo;
    logic [START_W-1:0]   cntstart;
    logic [STOP_W-1:0]    cntstop;
    logic                 gate_en;
    logic [STOP_W-1:0]    win_lo, win_hi;
    logic [STOP_W-1:0]    cnt_stop;
    logic [START_W-1:0]   cnt_start;
    logic [SEQ_W-1:0]     sequence_count;
    logic [NCH*CNT_W-1:0] cnt_photo, snap_photo;
    logic                 snap_valid;
    logic [NCH-1:0]       ovf;
    logic                 ready;

    count_multi_gate #(
        .NCH(NCH), .CNT_W(CNT_W), .STOP_W(STOP_W), .START_W(START_W),
        .SEQ_W(SEQ_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk500(clk500), .count_rst_n(count_rst_n), .start(start), .start_rst(start_rst),
        .photo_rst(photo_rst), .photo(photo), .cntstart(cntstart), .cntstop(cntstop),
        .gate_en(gate_en), .win_lo(win_lo), .win_hi(win_hi), .cnt_stop(cnt_stop),
        .cnt_start(cnt_start), .sequence_count(sequence_count), .cnt_photo(cnt_photo),
        .snap_photo(snap_photo), .snap_valid(snap_valid), .ovf(ovf), .ready(ready)
    );

    always #1 clk500 = ~clk500;

    int cyc = 0;
    always @(posedge clk500) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef enum int {K_STOP, K_START, K_SEQ, K_PHOTO, K_SNAP, K_SVALID, K_OVF, K_READY} kind_t;
    typedef struct {
        int          due;
        kind_t       kind;
        int          ch;
        logic [63:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    // reference model state
    int             stop_zero;
    int             exp_start = 0;
    int             exp_seq = 0;
    int             exp_cnt[NCH];
    logic [NCH-1:0] exp_ovf = '0;

    function automatic logic [63:0] actual(kind_t k, int ch);
        case (k)
            K_STOP:   return 64'(cnt_stop);
            K_START:  return 64'(cnt_start);
            K_SEQ:    return 64'(sequence_count);
            K_PHOTO:  return 64'(cnt_photo[ch*CNT_W +: CNT_W]);
            K_SNAP:   return 64'(snap_photo[ch*CNT_W +: CNT_W]);
            K_SVALID: return 64'(snap_valid);
            K_OVF:    return 64'(ovf);
            default:  return 64'(ready);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0d (cyc %0d)", name, act, cyc);
        end
    endtask

    task automatic push(input int due, input kind_t k, input int ch, input logic [63:0] exp,
                        input string name);
        exp_t e;
        e.due = due; e.kind = k; e.ch = ch; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    // Scoreboard: compare every entry that falls due at this cycle
    always @(negedge clk500) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, actual(sb[i].kind, sb[i].ch), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk500);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk500);
    endtask

    function automatic int next_start();
        return (exp_start >= int'(cntstart)) ? 1 : exp_start + 1;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, ".cnt_stop"}, 64'(cnt_stop), 0);
        check({tag, ".cnt_start"}, 64'(cnt_start), 0);
        check({tag, ".seq"}, 64'(sequence_count), 0);
        check({tag, ".cnt_photo"}, 64'(cnt_photo), 0);
        check({tag, ".snap_photo"}, 64'(snap_photo), 0);
        check({tag, ".snap_valid"}, 64'(snap_valid), 0);
        check({tag, ".ovf"}, 64'(ovf), 0);
        check({tag, ".ready"}, 64'(ready), 1);
    endtask

    // Start pulse of len cycles; exp is the cnt_start required once it lands
    task automatic do_start(input int len, input int exp);
        int c;
        c = cyc;
        start = 1'b1;
        wait_cyc(len);
        start = 1'b0;
        if (len >= 2) begin
            push(c + 3, K_STOP, 0, c + 3 - stop_zero, "cnt_stop_before_start");
            push(c + 4, K_STOP, 0, 0, "cnt_stop_at_start");
            push(c + 4, K_START, 0, exp, "cnt_start");
            exp_start = exp;
            stop_zero = c + 4;
        end else begin
            push(c + 4, K_STOP, 0, c + 4 - stop_zero, "cnt_stop_after_glitch");
            push(c + 4, K_START, 0, exp, "cnt_start_after_glitch");
        end
    endtask

    task automatic photon(input logic [NCH-1:0] mask, input bit win);
        int c;
        c = cyc;
        photo = mask;
        wait_cyc(1);
        photo = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch] && win) begin
                if (exp_cnt[ch] == CMAX) exp_ovf[ch] = 1'b1;
                else                     exp_cnt[ch]++;
            end
            push(c + 4, K_PHOTO, ch, exp_cnt[ch], $sformatf("cnt_photo[%0d]", ch));
        end
        push(c + 4, K_OVF, 0, 64'(exp_ovf), "ovf");
        wait_cyc(1);
    endtask

    task automatic photo_clear();
        int c;
        c = cyc;
        photo_rst = 1'b1;
        wait_cyc(3);
        photo_rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_cnt[ch] = 0;
            push(c + 4, K_PHOTO, ch, 0, $sformatf("cleared cnt_photo[%0d]", ch));
        end
        exp_ovf = '0;
        push(c + 4, K_OVF, 0, 0, "cleared ovf");
        wait_cyc(3);
    endtask

    typedef struct { int len; int exp_start; } start_vec_t;
    typedef struct { bit gate; int lo; int hi; int v; int exp0; } win_vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        start_vec_t svec[6];
        win_vec_t   wvec[9];
        int c, td;

        svec = '{'{3, 1}, '{3, 2}, '{1, 2}, '{3, 3}, '{3, 1}, '{3, 2}};
        wvec = '{'{1, 10, 20, 5, 0}, '{1, 10, 20, 10, 1}, '{1, 10, 20, 20, 2}, '{1, 10, 20, 21, 2},
                 '{0, 10, 20, 5, 1}, '{0, 10, 20, 10, 2}, '{0, 10, 20, 20, 3}, '{0, 10, 20, 21, 4},
                 '{1, 30, 10, 20, 4}};
        for (int ch = 0; ch < NCH; ch++) exp_cnt[ch] = 0;

        count_rst_n = 1'b0;
        start = 1'b0; start_rst = 1'b0; photo_rst = 1'b0; photo = '0;
        cntstart = 3; cntstop = 0; gate_en = 1'b0; win_lo = 0; win_hi = 0;

        // reset, then free-running cnt_stop with cntstop = 0
        wait_cyc(2);
        check_reset_state("reset");
        wait_cyc(2);
        count_rst_n = 1'b1;
        stop_zero = cyc;
        wait_cyc(1);
        check("ready_after_release", 64'(ready), 0);
        check("cnt_stop_1", 64'(cnt_stop), 1);
        wait_cyc(1);
        check("cnt_stop_2", 64'(cnt_stop), 2);
        wait_cyc(1);
        check("cnt_stop_3", 64'(cnt_stop), 3);

        // start counter wrap at cntstart, with a rejected 1-cycle glitch
        for (int i = 0; i < 6; i++) begin
            do_start(svec[i].len, svec[i].exp_start);
            wait_cyc(6);
        end

        // gated photon window, then ungated, then an inverted (empty) window
        for (int i = 0; i < 9; i++) begin
            if (i == 4) photo_clear();
            gate_en = wvec[i].gate;
            win_lo  = wvec[i].lo;
            win_hi  = wvec[i].hi;
            do_start(3, next_start());
            td = stop_zero + wvec[i].v - 3;
            wait_until(td);
            photon(4'b0001, !wvec[i].gate || (wvec[i].v >= wvec[i].lo && wvec[i].v <= wvec[i].hi));
            wait_until(td + 4);
            check($sformatf("window_vec%0d ch0", i), 64'(cnt_photo[0 +: CNT_W]), wvec[i].exp0);
        end

        // saturation and sticky overflow on ch2
        photo_clear();
        gate_en = 1'b0;
        repeat (17) photon(4'b0100, 1'b1);
        wait_cyc(4);
        check("sat cnt_photo[2]", 64'(cnt_photo[2*CNT_W +: CNT_W]), 15);
        check("sat ovf", 64'(ovf), 4'b0100);
        photo_clear();

        // snapshot on start_rst with a simultaneous start
        repeat (7) photon(4'b0011, 1'b1);
        wait_cyc(4);
        c = cyc;
        start_rst = 1'b1; start = 1'b1;
        wait_cyc(3);
        start_rst = 1'b0; start = 1'b0;
        for (int ch = 0; ch < NCH; ch++)
            push(c + 4, K_SNAP, ch, exp_cnt[ch], $sformatf("snap_photo[%0d]", ch));
        push(c + 3, K_SVALID, 0, 0, "snap_valid_before");
        push(c + 4, K_SVALID, 0, 1, "snap_valid_pulse");
        push(c + 5, K_SVALID, 0, 0, "snap_valid_after");
        exp_seq++;
        push(c + 4, K_SEQ, 0, exp_seq, "sequence_count");
        push(c + 4, K_START, 0, 0, "cnt_start_on_start_rst");
        push(c + 4, K_STOP, 0, 0, "cnt_stop_on_start_rst");
        exp_start = 0;
        stop_zero = c + 4;
        wait_cyc(4);

        // start_rst + photo_rst + photon together: pre-clear snapshot, photon dropped
        repeat (2) photon(4'b0010, 1'b1);
        wait_cyc(4);
        c = cyc;
        start_rst = 1'b1; photo_rst = 1'b1; photo = 4'b0001;
        wait_cyc(1);
        photo = '0;
        wait_cyc(2);
        start_rst = 1'b0; photo_rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            push(c + 4, K_SNAP, ch, exp_cnt[ch], $sformatf("snap_preclear[%0d]", ch));
            push(c + 4, K_PHOTO, ch, 0, $sformatf("clr_drop cnt_photo[%0d]", ch));
            push(c + 6, K_PHOTO, ch, 0, $sformatf("clr_late cnt_photo[%0d]", ch));
            exp_cnt[ch] = 0;
        end
        push(c + 4, K_SVALID, 0, 1, "snap_valid_pulse2");
        exp_seq++;
        push(c + 4, K_SEQ, 0, exp_seq, "sequence_count2");
        wait_cyc(6);

        // ready threshold
        cntstop = 100;
        do_start(3, next_start());
        push(stop_zero + 100, K_STOP, 0, 100, "cnt_stop_100");
        push(stop_zero + 100, K_READY, 0, 1, "ready_at_100");
        push(stop_zero + 101, K_READY, 0, 0, "ready_fall");
        wait_until(stop_zero + 102);
        do_start(3, next_start());
        push(stop_zero, K_READY, 0, 0, "ready_still_low");
        push(stop_zero + 1, K_READY, 0, 1, "ready_rise");
        wait_cyc(8);

        // mid-operation reset while a start is in the synchroniser
        c = cyc;
        start = 1'b1;
        wait_cyc(1);
        count_rst_n = 1'b0;
        wait_cyc(1);
        check_reset_state("midreset");
        start = 1'b0;
        count_rst_n = 1'b1;
        stop_zero = cyc;
        wait_cyc(4);
        check("midreset_no_pulse cnt_stop", 64'(cnt_stop), 64'(cyc - stop_zero));
        check("midreset cnt_start", 64'(cnt_start), 0);

        wait_cyc(4);
        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_multi_gate.md
Name: count_multi_gate

Overview:
Parametrised, multi-channel successor to the single-channel start/stop/photon counter in the clk500 timing path. It synchronises the external start, start_rst, photo_rst and NCH photon inputs, then maintains:
- a per-period stop timer;
- a start counter with a PC-set modulus, and a sequence counter;
- gated, saturating per-channel photon counters.

Per-sequence snapshots of the photon counts are delivered to the PC-side readout logic with a valid strobe.

Parameters:
NCH, 4, number of photon channels
CNT_W, 24, per-channel photon counter width
STOP_W, 32, stop-timer width
START_W, 24, start-counter width
SEQ_W, 32, sequence-counter width
SYNC_STAGES, 2, synchroniser depth on every async input (>=2)

Ports:
clk500  in  1  500 MHz clock, single clock domain
count_rst_n  in  1  reset, synchronous, active-low
start  in  1  async start pulse
start_rst  in  1  async sequence-reset pulse
photo_rst  in  1  async photon-counter clear
photo  in  NCH  async photon arrival, one bit per channel
cntstart  in  START_W  start-counter upper limit (PC)
cntstop  in  STOP_W  stop-timer ready threshold (PC)
gate_en  in  1  1 = count photons only inside window
win_lo  in  STOP_W  window start, inclusive, in cnt_stop ticks
win_hi  in  STOP_W  window end, inclusive
cnt_stop  out  STOP_W  clk500 ticks since last start
cnt_start  out  START_W  start count within sequence
sequence_count  out  SEQ_W  number of start_rst events
cnt_photo  out  NCH*CNT_W  live counts, channel i at bits [i*CNT_W +: CNT_W]
snap_photo  out  NCH*CNT_W  counts latched at start_rst
snap_valid  out  1  one-cycle strobe, snap_photo updated
ovf  out  NCH  sticky per-channel saturation flag
ready  out  1  0 once cnt_stop >= cntstop

Behaviour:
- Reset: count_rst_n=0 at a clk500 edge clears all synchroniser, history and pulse flops and every output to 0, except ready=1. Reset overrides all events in that cycle.
- Synchronisation, per input: chain s[0..SYNC_STAGES-1], plus history flop h (h <= s[last]).
- Edge detection:
  - photo_det[i] = s[last] & ~h.
  - start/start_rst/photo_rst det = s[last-1] & s[last] & ~h. These require >=2 consecutive high samples; a 1-cycle glitch is rejected.
- Pulse timing: each det is registered into a one-cycle *_pos pulse. If an input is first sampled high at edge k, *_pos is high after edge k+SYNC_STAGES, and its effect on counters is visible after edge k+SYNC_STAGES+1. A held-high input yields exactly one pulse.
- cnt_stop:
  - start_pos sets it to 0 at the next edge; otherwise it increments.
  - It saturates at all-ones and does not wrap.
- ready: registered each cycle as (cnt_stop < cntstop).
- in_win: (cnt_stop >= win_lo) && (cnt_stop <= win_hi), evaluated on the current cnt_stop in the photo_pos cycle.
  - Forced to 1 when gate_en=0.
  - win_lo > win_hi gives an empty window.
- cnt_photo[i], in priority order:
  1. photo_rst_pos clears all channels and all ovf bits; a same-cycle photon is dropped.
  2. Else photo_pos[i] & in_win increments the channel.
  3. At max value the counter holds and ovf[i] <= 1 (sticky).
  - Channels are independent; simultaneous photons on multiple channels all count.
- cnt_start / sequence_count:
  - start_rst_pos: cnt_start <= 0 and sequence_count increments (wraps). This has priority over a same-cycle start_pos.
  - Else start_pos: if cnt_start >= cntstart then cnt_start <= 1, else cnt_start increments.
- Snapshot:
  - On start_rst_pos, snap_photo <= cnt_photo (pre-update value of that cycle) and snap_valid=1 for exactly one cycle.
  - If photo_rst_pos coincides, the snapshot takes the pre-clear counts.
  - snap_photo holds otherwise.
- Mid-operation reset: any count_rst_n low edge returns the block to reset state; no partial pulses survive.
- Intended RTL is a generate loop over NCH for sync, counters and ovf.

Test Plan:
1. count_rst_n=0 for 4 edges, then 1, cntstop=0 -> all outputs 0, ready=1 during reset; ready=0 one edge after release (0>=0); cnt_stop counts 1,2,3...
2. cntstart=3; five 3-cycle start pulses, plus one 1-cycle start glitch -> cnt_start 1,2,3,1,2; glitch ignored; cnt_stop reads 0 exactly SYNC_STAGES+1 edges after each start sample edge.
3. gate_en=1, win_lo=10, win_hi=20; ch0 photons timed so photo_pos coincides with cnt_stop=5,10,20,21 -> cnt_photo[0]=2. Repeat with gate_en=0 -> 4.
4. CNT_W=4; 17 photons on ch2 -> cnt_photo[2]=15, ovf=4'b0100; photo_rst pulse -> counts and ovf return to 0.
5. cnt_photo[1]=7, then start_rst together with start -> snap_photo[1]=7, snap_valid high for 1 cycle, sequence_count +1, cnt_start=0 (start ignored).
6. cntstop=100 -> ready falls one edge after cnt_stop reaches 100, and returns to 1 one edge after cnt_stop is reset by start.
